// File: rtl/pipeline_hazard_ctrl.sv
// In-order issue control: a per-register pending-latency scoreboard detects
// RAW/WAW hazards, and a short FLUSH state squashes wrong-path slots after a branch.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int unsigned ALU_LAT    = 3,
  parameter int unsigned LOAD_LAT   = 4,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  input  logic [3:0]  srcC,
  input  logic [2:0]  srcUse,
  input  logic [3:0]  dst,
  input  logic        dstWe,
  input  logic        isLoad,
  input  logic        isBranch,
  output logic        issue,
  output logic        stall,
  output logic        bubble,
  output logic        squash,
  output logic [15:0] stallCount
);

  localparam logic [2:0] ALU_L  = 3'(ALU_LAT);
  localparam logic [2:0] LOAD_L = 3'(LOAD_LAT);
  localparam logic [2:0] BR_L   = 3'(BR_PENALTY);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]  cnt_q [16];
  logic [2:0]  cnt_d [16];
  logic        hazard;

  always_comb begin
    hazard = 1'b0;
    if (srcUse[0] && cnt_q[srcA] != '0) hazard = 1'b1;
    if (srcUse[1] && cnt_q[srcB] != '0) hazard = 1'b1;
    if (srcUse[2] && cnt_q[srcC] != '0) hazard = 1'b1;
    if (dstWe && cnt_q[dst] != '0)      hazard = 1'b1;
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    issue  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b0;
    squash = 1'b0;
    if (reset) begin
      if (state_q == RUN) begin
        issue  = instrValid & ~hazard;
        stall  = instrValid & hazard;
        bubble = instrValid & hazard;
      end else begin
        bubble = 1'b1;
        squash = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 3'd1 : '0;
      if (issue && dstWe && dst == 4'(i)) cnt_d[i] = isLoad ? LOAD_L : ALU_L;
    end
    if (state_q == RUN) begin
      if (issue && isBranch && BR_L != '0) begin
        state_d     = FLUSH;
        flush_cnt_d = BR_L;
      end
    end else begin
      flush_cnt_d = flush_cnt_q - 3'd1;
      if (flush_cnt_q == 3'd1) state_d = RUN;
    end
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: a time-based reference model (register ready times, flush end
// time) predicts each cycle's outputs; a negedge monitor compares against the DUTs.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int ALU_LAT    = 3;
  localparam int LOAD_LAT   = 4;
  localparam int BR_PENALTY = 2;
  localparam int SAT_LAT    = 7;
  localparam int SAT_CYCLES = 75000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instrValid = 1'b0;
  logic [3:0]  srcA = '0, srcB = '0, srcC = '0, dst = '0;
  logic [2:0]  srcUse = '0;
  logic        dstWe = 1'b0, isLoad = 1'b0, isBranch = 1'b0;
  logic        issue, stall, bubble, squash;
  logic [15:0] stallCount;

  logic        rst_sat = 1'b0;
  logic        s_issue, s_stall, s_bubble, s_squash;
  logic [15:0] s_stallCount;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .BR_PENALTY(BR_PENALTY)) dut (
    .clk(clk), .reset(reset), .instrValid(instrValid),
    .srcA(srcA), .srcB(srcB), .srcC(srcC), .srcUse(srcUse),
    .dst(dst), .dstWe(dstWe), .isLoad(isLoad), .isBranch(isBranch),
    .issue(issue), .stall(stall), .bubble(bubble), .squash(squash),
    .stallCount(stallCount)
  );

  // Self-dependent load-branch loop with no branch penalty: 7 stalls per 8 cycles.
  pipeline_hazard_ctrl #(.ALU_LAT(SAT_LAT), .LOAD_LAT(SAT_LAT), .BR_PENALTY(0)) dut_sat (
    .clk(clk), .reset(rst_sat), .instrValid(1'b1),
    .srcA(4'd1), .srcB(4'd0), .srcC(4'd0), .srcUse(3'b001),
    .dst(4'd1), .dstWe(1'b1), .isLoad(1'b1), .isBranch(1'b1),
    .issue(s_issue), .stall(s_stall), .bubble(s_bubble), .squash(s_squash),
    .stallCount(s_stallCount)
  );

  typedef struct packed {
    logic        issue;
    logic        stall;
    logic        bubble;
    logic        squash;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t sat_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int ready_at [16];
  int flush_end = 0;
  int scnt = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [2:0] su, input logic [3:0] d,
                      input logic we, input logic ld, input logic br);
    exp_t e;
    logic haz;
    @(posedge clk);
    #1;
    reset = rst; instrValid = v; srcA = a; srcB = b; srcC = c; srcUse = su;
    dst = d; dstWe = we; isLoad = ld; isBranch = br;
    e = '0;
    if (!rst) begin
      foreach (ready_at[i]) ready_at[i] = 0;
      flush_end = 0;
      scnt = 0;
    end else begin
      haz = (su[0] && ready_at[a] > cyc) || (su[1] && ready_at[b] > cyc) ||
            (su[2] && ready_at[c] > cyc) || (we && ready_at[d] > cyc);
      e.sc = 16'(scnt);
      if (cyc < flush_end) begin
        e.bubble = 1'b1;
        e.squash = 1'b1;
      end else begin
        e.issue  = v && !haz;
        e.stall  = v && haz;
        e.bubble = v && haz;
      end
      if (e.stall && scnt < 65535) scnt++;
      if (e.issue && we) ready_at[d] = cyc + 1 + (ld ? LOAD_LAT : ALU_LAT);
      if (e.issue && br && BR_PENALTY > 0) flush_end = cyc + 1 + BR_PENALTY;
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = '{issue, stall, bubble, squash, stallCount};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL main_cycle: got iss=%b stl=%b bub=%b sq=%b sc=%0d expected iss=%b stl=%b bub=%b sq=%b sc=%0d (t=%0t)",
                 issue, stall, bubble, squash, stallCount,
                 e.issue, e.stall, e.bubble, e.squash, e.sc, $time);
      end
    end
    if (sat_q.size() > 0) begin
      e = sat_q.pop_front();
      act = '{s_issue, s_stall, s_bubble, s_squash, s_stallCount};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL sat_cycle: got iss=%b stl=%b bub=%b sq=%b sc=%0d expected iss=%b stl=%b bub=%b sq=%b sc=%0d (t=%0t)",
                 s_issue, s_stall, s_bubble, s_squash, s_stallCount,
                 e.issue, e.stall, e.bubble, e.squash, e.sc, $time);
      end
    end
  end

  initial begin
    foreach (ready_at[i]) ready_at[i] = 0;
    fork
      begin : main_seq
        logic rr, vv, ww, ll, bb;
        logic [3:0] ra, rb, rc, rd;
        logic [2:0] ru;
        step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'b111, 4'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd3, 4'd3, 4'd3, 3'b111, 4'd3, 1'b1, 1'b0, 1'b1);
        // back-to-back RAW on r3
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
          step(1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("raw_stallcount", 32'(stallCount), 32'd3);
        // load-use on r5 through srcC
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
          step(1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("loaduse_stallcount", 32'(stallCount), 32'd7);
        idle(5);
        // unused srcA matching a pending load destination
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd5, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'd5, 4'd1, 4'd2, 3'b110, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("unused_src_issue", 32'(issue), 32'd1);
        idle(5);
        // branch with link into r11, then a consumer of r11 held during the flush
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd11, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd11, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("flush_squash", 32'(squash), 32'd1);
        for (int i = 0; i < 3; i++)
          step(1'b1, 1'b1, 4'd11, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_flush_issue", 32'(issue), 32'd1);
        chk("branch_stallcount", 32'(stallCount), 32'd8);
        idle(5);
        // reset while flushing with r7 still pending
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_stallcount", 32'(stallCount), 32'd0);
        chk("reset_outputs", 32'({issue, stall, bubble, squash}), 32'd0);
        step(1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_r7_issue", 32'(issue), 32'd1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
          rr = ($urandom_range(0, 199) != 0);
          vv = ($urandom_range(0, 7) != 0);
          ra = 4'($urandom_range(0, 15));
          rb = 4'($urandom_range(0, 15));
          rc = 4'($urandom_range(0, 15));
          rd = 4'($urandom_range(0, 15));
          ru = 3'($urandom_range(0, 7));
          ww = 1'($urandom_range(0, 1));
          ll = 1'($urandom_range(0, 1));
          bb = ($urandom_range(0, 7) == 0);
          step(rr, vv, ra, rb, rc, ru, rd, ww, ll, bb);
        end
        idle(2);
      end
      begin : sat_seq
        exp_t e;
        int stalls;
        @(posedge clk);
        #1;
        rst_sat = 1'b1;
        for (int k = 0; k < SAT_CYCLES; k++) begin
          stalls = k - (k + 7) / 8;
          e = '0;
          e.issue  = (k % 8 == 0);
          e.stall  = (k % 8 != 0);
          e.bubble = (k % 8 != 0);
          e.sc     = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
          sat_q.push_back(e);
          @(posedge clk);
          #1;
        end
        @(negedge clk);
        chk("sat_stallcount", 32'(s_stallCount), 32'h0000FFFF);
      end
    join
    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(exp_q.size() + sat_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
